regfile_read_arbiter: RTL and testbench

Shares the single 32-to-1 register-file read port (5-bit selector, N-bit data) among NUM_REQ requesters, such as the decode stage, a debug/scan unit and an exception unit.
- Grants at most one request per cycle using round-robin priority.
- Drives the register-file read-mux selector combinationally.
- Holds each requester's read result in a per-requester response register until the requester acknowledges it (valid/ready).
- Sits between the requesters and the register-file read mux.

---
 rtl/regfile_read_arbiter.sv | 92 +++++++++
 tb/tb_regfile_read_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters,
// with a per-requester response register released by a valid/ready handshake.
module regfile_read_arbiter #(
  parameter int N        = 32,
  parameter int NUM_REQ  = 4,
  parameter int ZERO_REG = 1,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [5*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [4:0]             rd_sel,
  input  logic [N-1:0]           rd_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [N*NUM_REQ-1:0]   rsp_data,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [IDW-1:0]         grant_id
);

  logic [IDW-1:0]     r_ptr;
  logic [NUM_REQ-1:0] r_rspValid;
  logic [N-1:0]       r_rspData [NUM_REQ];

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_grant;
  logic [IDW-1:0]     w_winner;
  logic [4:0]         w_winAddr;
  logic [NUM_REQ-1:0] w_oneHot;
  logic [N-1:0]       w_fillData;
  logic [IDW-1:0]     w_ptrNext;
  int                 w_idx;

  // A full slot may still be granted when it drains in the same cycle
  assign w_eligible = req_valid & (~r_rspValid | rsp_ready);

  // Scan from furthest to nearest so the index closest to r_ptr wins last
  always_comb begin
    w_grant   = 1'b0;
    w_winner  = '0;
    w_winAddr = '0;
    w_oneHot  = '0;
    w_idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (w_eligible[w_idx]) begin
        w_grant          = 1'b1;
        w_winner         = IDW'(w_idx);
        w_winAddr        = req_addr[5*w_idx +: 5];
        w_oneHot         = '0;
        w_oneHot[w_idx]  = 1'b1;
      end
    end
  end

  assign req_ready  = w_oneHot;
  assign rd_sel     = w_winAddr;
  assign grant_id   = w_winner;
  assign w_fillData = ((ZERO_REG != 0) && (w_winAddr == 5'd0)) ? '0 : rd_data;
  assign w_ptrNext  = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr      <= '0;
      r_rspValid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rspData[i] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_ptr <= w_ptrNext;
      end
      // A grant refills the slot even when its old response drains this cycle
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_oneHot[i]) begin
          r_rspValid[i] <= 1'b1;
          r_rspData[i]  <= w_fillData;
        end else if (rsp_ready[i]) begin
          r_rspValid[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = r_rspValid;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rspFlat
    assign rsp_data[N*g +: N] = r_rspData[g];
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed plus random bench for regfile_read_arbiter, with ZERO_REG=1 and ZERO_REG=0
// instances driven in parallel and compared against a queue-free behavioural model.
module tb_regfile_read_arbiter;
  localparam int N  = 32;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   reqValid;
  logic [5*NR-1:0] reqAddr;
  logic [NR-1:0]   rspReady;
  logic            forceOnes;

  logic [NR-1:0]   reqReady,  reqReadyNz;
  logic [4:0]      rdSel,     rdSelNz;
  logic [N-1:0]    rdData,    rdDataNz;
  logic [NR-1:0]   rspValid,  rspValidNz;
  logic [N*NR-1:0] rspData,   rspDataNz;
  logic [1:0]      grantId,   grantIdNz;

  logic [N-1:0]    regs [32];

  int              errors = 0;
  int              checks = 0;

  int              mPtr;
  logic [NR-1:0]   mValid;
  logic [N-1:0]    mData   [NR];
  logic [N-1:0]    mDataNz [NR];
  bit              mKnown = 1'b0;

  always #5 clk = ~clk;

  assign rdData   = forceOnes ? '1 : regs[rdSel];
  assign rdDataNz = forceOnes ? '1 : regs[rdSelNz];

  regfile_read_arbiter #(.N(N), .NUM_REQ(NR), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_addr(reqAddr),
    .req_ready(reqReady), .rd_sel(rdSel), .rd_data(rdData),
    .rsp_valid(rspValid), .rsp_data(rspData), .rsp_ready(rspReady),
    .grant_id(grantId)
  );

  regfile_read_arbiter #(.N(N), .NUM_REQ(NR), .ZERO_REG(0)) dutNz (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_addr(reqAddr),
    .req_ready(reqReadyNz), .rd_sel(rdSelNz), .rd_data(rdDataNz),
    .rsp_valid(rspValidNz), .rsp_data(rspDataNz), .rsp_ready(rspReady),
    .grant_id(grantIdNz)
  );

  // Every comparison goes through here so the counters stay in one place
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check grant outputs, advance model at posedge, check responses
  task automatic applyStimulus(input logic rstN, input logic [NR-1:0] v, input logic [5*NR-1:0] a,
                               input logic [NR-1:0] rr, input logic f);
    int              win;
    int              idx;
    logic [NR-1:0]   expReady;
    logic [4:0]      expSel;
    logic [N-1:0]    raw;
    logic [N*NR-1:0] flat, flatNz;
    @(negedge clk);
    reset = rstN; reqValid = v; reqAddr = a; rspReady = rr; forceOnes = f;
    #1;
    win = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (mPtr + k) % NR;
      if (win < 0 && v[idx] && (!mValid[idx] || rr[idx])) win = idx;
    end
    expReady = '0;
    expSel   = '0;
    if (win >= 0) begin
      expReady[win] = 1'b1;
      expSel        = a[5*win +: 5];
    end
    if (mKnown) begin
      checkOutput("reqReady",   128'(reqReady),   128'(expReady));
      checkOutput("rdSel",      128'(rdSel),      128'(expSel));
      checkOutput("grantId",    128'(grantId),    128'((win >= 0) ? win : 0));
      checkOutput("reqReadyNz", 128'(reqReadyNz), 128'(expReady));
      checkOutput("rdSelNz",    128'(rdSelNz),    128'(expSel));
    end
    raw = f ? '1 : regs[expSel];
    @(posedge clk);
    if (!rstN) begin
      mPtr = 0;
      mValid = '0;
      for (int i = 0; i < NR; i++) begin mData[i] = '0; mDataNz[i] = '0; end
      mKnown = 1'b1;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (i == win) begin
          mValid[i]  = 1'b1;
          mData[i]   = (expSel == 5'd0) ? '0 : raw;
          mDataNz[i] = raw;
        end else if (rr[i]) begin
          mValid[i] = 1'b0;
        end
      end
      if (win >= 0) mPtr = (win + 1) % NR;
    end
    #1;
    if (mKnown) begin
      for (int i = 0; i < NR; i++) begin
        flat[N*i +: N]   = mData[i];
        flatNz[N*i +: N] = mDataNz[i];
      end
      checkOutput("rspValid",   128'(rspValid),   128'(mValid));
      checkOutput("rspData",    128'(rspData),    128'(flat));
      checkOutput("rspValidNz", 128'(rspValidNz), 128'(mValid));
      checkOutput("rspDataNz",  128'(rspDataNz),  128'(flatNz));
    end
  endtask

  initial begin
    logic [5*NR-1:0] a;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h1234_5678;
    regs[9] = 32'hDEAD_BEEF;
    reset = 1'b0; reqValid = '0; reqAddr = '0; rspReady = '0; forceOnes = 1'b0;
    mPtr = 0; mValid = '0;
    for (int i = 0; i < NR; i++) begin mData[i] = '0; mDataNz[i] = '0; end

    $display("[TB] reset with all requesters pending");
    a = {5'd4, 5'd3, 5'd2, 5'd1};
    applyStimulus(1'b0, 4'hF, a, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'hF, a, 4'h0, 1'b0);
    checkOutput("rstRspValid", 128'(rspValid), 128'(0));
    checkOutput("rstRspData",  128'(rspData),  128'(0));
    applyStimulus(1'b1, 4'hF, a, 4'hF, 1'b0);
    checkOutput("firstGrant0", 128'(rspValid), 128'(4'b0001));

    $display("[TB] single request to r9");
    applyStimulus(1'b1, 4'h0, '0, 4'hF, 1'b0);
    a = '0; a[9:5] = 5'd9;
    applyStimulus(1'b1, 4'b0010, a, 4'hF, 1'b0);
    checkOutput("singleData", 128'(rspData[63:32]), 128'(32'hDEAD_BEEF));

    $display("[TB] round robin with all requesters pending");
    a = {5'd7, 5'd6, 5'd5, 5'd9};
    applyStimulus(1'b0, 4'h0, a, 4'hF, 1'b0);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 4'hF, a, 4'hF, 1'b0);

    $display("[TB] backpressure on requester 2");
    applyStimulus(1'b1, 4'b0100, a, 4'hF, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 4'hF, a, 4'b1011, 1'b0);
    a[14:10] = 5'd9;
    applyStimulus(1'b1, 4'b0100, a, 4'hF, 1'b0);
    checkOutput("refillValid2", 128'(rspValid[2]), 128'(1'b1));
    checkOutput("refillData2",  128'(rspData[95:64]), 128'(32'hDEAD_BEEF));

    $display("[TB] zero register with forced ones");
    a = '0;
    applyStimulus(1'b1, 4'b1000, a, 4'hF, 1'b1);
    checkOutput("zeroRegOn",  128'(rspData[127:96]),   128'(0));
    checkOutput("zeroRegOff", 128'(rspDataNz[127:96]), 128'(32'hFFFF_FFFF));

    $display("[TB] reset during a grant");
    a = {5'd3, 5'd3, 5'd9, 5'd3};
    applyStimulus(1'b1, 4'hF, a, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'b0010, a, 4'h0, 1'b0);
    checkOutput("midRstValid", 128'(rspValid), 128'(0));
    applyStimulus(1'b1, 4'b1110, a, 4'h0, 1'b0);
    checkOutput("postRstGrant", 128'(rspValid), 128'(4'b0010));

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) a[5*i +: 5] = 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 49) != 0), 4'($urandom), a, 4'($urandom),
                    ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
